// File: rtl/control_unit_module_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_module_pkg
// Shared encodings for the multicycle RV32I control unit: FSM state enum,
// ALU operation codes, sign-extend modes, RV32I opcodes, datapath mux selects,
// and small decode helpers used by the FSM.
// -----------------------------------------------------------------------------
package control_unit_module_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_EXEC_R    = 4'd2,
      ST_EXEC_I    = 4'd3,
      ST_ALU_WB    = 4'd4,
      ST_LUI       = 4'd5,
      ST_MEM_ADDR  = 4'd6,
      ST_MEM_READ  = 4'd7,
      ST_MEM_WB    = 4'd8,
      ST_MEM_WRITE = 4'd9,
      ST_BRANCH    = 4'd10,
      ST_JALR_ADDR = 4'd11,
      ST_LINK      = 4'd12,
      ST_JUMP      = 4'd13
   } state_e;

   // Register-register ops honour funct7[5] for SUB; immediate ops only for SRAI.
   typedef enum logic {
      CLASS_R = 1'b0,
      CLASS_I = 1'b1
   } alu_class_e;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   // Sign-extend unit modes
   localparam logic [3:0] IMM_I   = 4'd0;
   localparam logic [3:0] IMM_S   = 4'd1;
   localparam logic [3:0] IMM_B   = 4'd2;
   localparam logic [3:0] IMM_U   = 4'd3;
   localparam logic [3:0] IMM_J   = 4'd4;
   localparam logic [3:0] IMM_LB  = 4'd5;
   localparam logic [3:0] IMM_LH  = 4'd6;
   localparam logic [3:0] IMM_LBU = 4'd7;
   localparam logic [3:0] IMM_LHU = 4'd8;
   localparam logic [3:0] IMM_LW  = 4'd9;

   // RV32I major opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Datapath mux selects
   localparam logic       MEMSEL_PC   = 1'b0;
   localparam logic       MEMSEL_ALU  = 1'b1;
   localparam logic       ALUMUX_REG  = 1'b0;
   localparam logic       ALUMUX_LIVE = 1'b1;
   localparam logic [1:0] RFMUX_MEM   = 2'b00;
   localparam logic [1:0] RFMUX_ALU   = 2'b01;
   localparam logic [1:0] RFMUX_SEXT  = 2'b10;
   localparam logic [1:0] OP1_RS1     = 2'b00;
   localparam logic [1:0] OP1_PC      = 2'b01;
   localparam logic [1:0] OP1_OLDPC   = 2'b10;
   localparam logic [1:0] OP2_IMM     = 2'b00;
   localparam logic [1:0] OP2_FOUR    = 2'b01;
   localparam logic [1:0] OP2_RS2     = 2'b10;
   localparam logic [1:0] OP2_ZERO    = 2'b11;
   localparam logic [1:0] MODE_WORD   = 2'b00;
   localparam logic [1:0] MODE_HALF   = 2'b01;
   localparam logic [1:0] MODE_BYTE   = 2'b10;

   // Load/store access width; funct3[2] is only the unsigned flag.
   function automatic logic [1:0] access_mode(input logic [2:0] funct3);
      logic [1:0] mode;
      case (funct3[1:0])
         2'b00:   mode = MODE_BYTE;
         2'b01:   mode = MODE_HALF;
         default: mode = MODE_WORD;
      endcase
      return mode;
   endfunction

   // Sign-extend variant applied to loaded data before write-back.
   function automatic logic [3:0] load_imm_src(input logic [2:0] funct3);
      logic [3:0] src;
      case (funct3)
         3'b000:  src = IMM_LB;
         3'b001:  src = IMM_LH;
         3'b100:  src = IMM_LBU;
         3'b101:  src = IMM_LHU;
         default: src = IMM_LW;
      endcase
      return src;
   endfunction

   // Branch condition from the flags of rs1 - rs2; reserved funct3 never taken.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       negative,
                                         input logic       unegative);
      logic taken;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = negative;
         3'b101:  taken = ~negative;
         3'b110:  taken = unegative;
         3'b111:  taken = ~unegative;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/control_unit_module_alu_decode.sv
// -----------------------------------------------------------------------------
// alu_decode_module
// Maps (instruction class, funct3, funct7[5]) to the ALU operation code.
//   op_class : CLASS_R for register-register, CLASS_I for register-immediate
//   funct3   : ir[14:12]
//   funct7_5 : ir[30]
//   alu_sel  : ALU operation code
// -----------------------------------------------------------------------------
module alu_decode_module
   import control_unit_module_pkg::*;
(
   input  alu_class_e op_class,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_sel
);

   // funct3/funct7 to ALU operation; ir[30] on ADDI is immediate data, not SUB
   always_comb begin
      alu_sel = ALU_ADD;
      case (funct3)
         3'b000: begin
            if ((op_class == CLASS_R) && funct7_5) begin
               alu_sel = ALU_SUB;
            end else begin
               alu_sel = ALU_ADD;
            end
         end
         3'b001: alu_sel = ALU_SLL;
         3'b010: alu_sel = ALU_SLT;
         3'b011: alu_sel = ALU_SLTU;
         3'b100: alu_sel = ALU_XOR;
         3'b101: begin
            if (funct7_5) begin
               alu_sel = ALU_SRA;
            end else begin
               alu_sel = ALU_SRL;
            end
         end
         3'b110: alu_sel = ALU_OR;
         3'b111: alu_sel = ALU_AND;
         default: alu_sel = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/control_unit_module.sv
// -----------------------------------------------------------------------------
// control_unit_module
// Multicycle RV32I control FSM. Outputs decode combinationally from state, ir
// and flags, and are forced to 0 while reset is low.
//   clk, reset (async, active-low)
//   ir                : instruction register contents
//   zero/negative/unegative : ALU flags for branch resolution
//   mem_op_r          : memory operation complete
//   *_enable, rf_we   : register load enables
//   mem_enable, mem_write_enable : memory request / write
//   *_select, alu_sel, imm_src, instr_mode : datapath controls
//   illegal_instr     : one-cycle pulse on an undecodable opcode
// -----------------------------------------------------------------------------
module control_unit_module
   import control_unit_module_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        zero,
   input  logic        negative,
   input  logic        unegative,
   input  logic        mem_op_r,
   output logic        pc_enable,
   output logic        old_pc_enable,
   output logic        ir_reg_enable,
   output logic        mem_reg_enable,
   output logic        alu_reg_enable,
   output logic        rf_we,
   output logic        mem_enable,
   output logic        mem_write_enable,
   output logic        memsel_mux_select,
   output logic        alu_reg_mux_select,
   output logic [1:0]  regfile_mux_select,
   output logic [1:0]  opsel1_select,
   output logic [1:0]  opsel2_select,
   output logic [3:0]  alu_sel,
   output logic [3:0]  imm_src,
   output logic [1:0]  instr_mode,
   output logic        illegal_instr
);

   state_e     state_r;
   state_e     next_state_s;
   logic [6:0] opcode_s;
   logic [2:0] funct3_s;
   alu_class_e alu_class_s;
   logic [3:0] dec_alu_sel_s;
   logic       unused_ir_bits_s;

   logic       pc_enable_s, old_pc_enable_s, ir_reg_enable_s, mem_reg_enable_s;
   logic       alu_reg_enable_s, rf_we_s, mem_enable_s, mem_write_enable_s;
   logic       memsel_s, alu_reg_mux_s, illegal_s;
   logic [1:0] regfile_mux_s, opsel1_s, opsel2_s, instr_mode_s;
   logic [3:0] alu_sel_s, imm_src_s;

   assign opcode_s         = ir[6:0];
   assign funct3_s         = ir[14:12];
   assign alu_class_s      = (opcode_s == OP_R) ? CLASS_R : CLASS_I;
   // Register indices and immediate fields are consumed by the datapath only.
   assign unused_ir_bits_s = ^{ir[31], ir[29:15], ir[11:7]};

   alu_decode_module u_alu_decode (
      .op_class (alu_class_s),
      .funct3   (funct3_s),
      .funct7_5 (ir[30]),
      .alu_sel  (dec_alu_sel_s)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and per-state control decode
   always_comb begin
      next_state_s       = state_r;
      pc_enable_s        = 1'b0;
      old_pc_enable_s    = 1'b0;
      ir_reg_enable_s    = 1'b0;
      mem_reg_enable_s   = 1'b0;
      alu_reg_enable_s   = 1'b0;
      rf_we_s            = 1'b0;
      mem_enable_s       = 1'b0;
      mem_write_enable_s = 1'b0;
      memsel_s           = MEMSEL_PC;
      alu_reg_mux_s      = ALUMUX_REG;
      regfile_mux_s      = RFMUX_MEM;
      opsel1_s           = OP1_RS1;
      opsel2_s           = OP2_IMM;
      alu_sel_s          = ALU_ADD;
      imm_src_s          = IMM_I;
      instr_mode_s       = MODE_WORD;
      illegal_s          = 1'b0;

      case (state_r)
         ST_FETCH: begin
            mem_enable_s = 1'b1;
            memsel_s     = MEMSEL_PC;
            instr_mode_s = MODE_WORD;
            if (mem_op_r) begin
               // Latch the instruction, remember its pc, and advance pc by 4.
               ir_reg_enable_s = 1'b1;
               old_pc_enable_s = 1'b1;
               pc_enable_s     = 1'b1;
               opsel1_s        = OP1_PC;
               opsel2_s        = OP2_FOUR;
               alu_sel_s       = ALU_ADD;
               alu_reg_mux_s   = ALUMUX_LIVE;
               next_state_s    = ST_DECODE;
            end else begin
               next_state_s    = ST_FETCH;
            end
         end
         ST_DECODE: begin
            // old_pc + imm serves both as branch/jal target and auipc result.
            case (opcode_s)
               OP_R:      begin imm_src_s = IMM_I; next_state_s = ST_EXEC_R;    end
               OP_I:      begin imm_src_s = IMM_I; next_state_s = ST_EXEC_I;    end
               OP_LOAD:   begin imm_src_s = IMM_I; next_state_s = ST_MEM_ADDR;  end
               OP_STORE:  begin imm_src_s = IMM_S; next_state_s = ST_MEM_ADDR;  end
               OP_BRANCH: begin imm_src_s = IMM_B; next_state_s = ST_BRANCH;    end
               OP_JAL:    begin imm_src_s = IMM_J; next_state_s = ST_LINK;      end
               OP_JALR:   begin imm_src_s = IMM_I; next_state_s = ST_JALR_ADDR; end
               OP_LUI:    begin imm_src_s = IMM_U; next_state_s = ST_LUI;       end
               OP_AUIPC:  begin imm_src_s = IMM_U; next_state_s = ST_ALU_WB;    end
               default: begin
                  imm_src_s    = IMM_I;
                  illegal_s    = 1'b1;
                  next_state_s = ST_FETCH;
               end
            endcase
            if (!illegal_s) begin
               opsel1_s         = OP1_OLDPC;
               opsel2_s         = OP2_IMM;
               alu_sel_s        = ALU_ADD;
               alu_reg_enable_s = 1'b1;
            end else begin
               alu_reg_enable_s = 1'b0;
            end
         end
         ST_EXEC_R: begin
            opsel1_s         = OP1_RS1;
            opsel2_s         = OP2_RS2;
            alu_sel_s        = dec_alu_sel_s;
            alu_reg_enable_s = 1'b1;
            next_state_s     = ST_ALU_WB;
         end
         ST_EXEC_I: begin
            opsel1_s         = OP1_RS1;
            opsel2_s         = OP2_IMM;
            imm_src_s        = IMM_I;
            alu_sel_s        = dec_alu_sel_s;
            alu_reg_enable_s = 1'b1;
            next_state_s     = ST_ALU_WB;
         end
         ST_ALU_WB: begin
            rf_we_s       = 1'b1;
            regfile_mux_s = RFMUX_ALU;
            alu_reg_mux_s = ALUMUX_REG;
            next_state_s  = ST_FETCH;
         end
         ST_LUI: begin
            rf_we_s       = 1'b1;
            regfile_mux_s = RFMUX_SEXT;
            imm_src_s     = IMM_U;
            next_state_s  = ST_FETCH;
         end
         ST_MEM_ADDR: begin
            opsel1_s         = OP1_RS1;
            opsel2_s         = OP2_IMM;
            alu_sel_s        = ALU_ADD;
            alu_reg_enable_s = 1'b1;
            if (opcode_s == OP_STORE) begin
               imm_src_s    = IMM_S;
               next_state_s = ST_MEM_WRITE;
            end else begin
               imm_src_s    = IMM_I;
               next_state_s = ST_MEM_READ;
            end
         end
         ST_MEM_READ: begin
            mem_enable_s  = 1'b1;
            memsel_s      = MEMSEL_ALU;
            alu_reg_mux_s = ALUMUX_REG;
            instr_mode_s  = access_mode(funct3_s);
            if (mem_op_r) begin
               mem_reg_enable_s = 1'b1;
               next_state_s     = ST_MEM_WB;
            end else begin
               next_state_s     = ST_MEM_READ;
            end
         end
         ST_MEM_WB: begin
            rf_we_s       = 1'b1;
            regfile_mux_s = RFMUX_SEXT;
            imm_src_s     = load_imm_src(funct3_s);
            next_state_s  = ST_FETCH;
         end
         ST_MEM_WRITE: begin
            mem_enable_s       = 1'b1;
            mem_write_enable_s = 1'b1;
            memsel_s           = MEMSEL_ALU;
            alu_reg_mux_s      = ALUMUX_REG;
            instr_mode_s       = access_mode(funct3_s);
            if (mem_op_r) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_MEM_WRITE;
            end
         end
         ST_BRANCH: begin
            opsel1_s     = OP1_RS1;
            opsel2_s     = OP2_RS2;
            alu_sel_s    = ALU_SUB;
            next_state_s = ST_FETCH;
            // Taken: pc loads the target held in the ALU register since DECODE.
            if (branch_taken(funct3_s, zero, negative, unegative)) begin
               pc_enable_s   = 1'b1;
               alu_reg_mux_s = ALUMUX_REG;
            end else begin
               pc_enable_s   = 1'b0;
            end
         end
         ST_JALR_ADDR: begin
            // Target captured before LINK overwrites rd, which may equal rs1.
            opsel1_s         = OP1_RS1;
            opsel2_s         = OP2_IMM;
            imm_src_s        = IMM_I;
            alu_sel_s        = ALU_ADD;
            alu_reg_enable_s = 1'b1;
            next_state_s     = ST_LINK;
         end
         ST_LINK: begin
            // pc already holds old_pc + 4, so rd = pc + 0.
            opsel1_s      = OP1_PC;
            opsel2_s      = OP2_ZERO;
            alu_sel_s     = ALU_ADD;
            alu_reg_mux_s = ALUMUX_LIVE;
            rf_we_s       = 1'b1;
            regfile_mux_s = RFMUX_ALU;
            next_state_s  = ST_JUMP;
         end
         ST_JUMP: begin
            pc_enable_s   = 1'b1;
            alu_reg_mux_s = ALUMUX_REG;
            next_state_s  = ST_FETCH;
         end
         default: begin
            next_state_s = ST_FETCH;
         end
      endcase
   end

   // Reset masks every output immediately, including a pending memory wait.
   assign pc_enable          = reset & pc_enable_s;
   assign old_pc_enable      = reset & old_pc_enable_s;
   assign ir_reg_enable      = reset & ir_reg_enable_s;
   assign mem_reg_enable     = reset & mem_reg_enable_s;
   assign alu_reg_enable     = reset & alu_reg_enable_s;
   assign rf_we              = reset & rf_we_s;
   assign mem_enable         = reset & mem_enable_s;
   assign mem_write_enable   = reset & mem_write_enable_s;
   assign memsel_mux_select  = reset & memsel_s;
   assign alu_reg_mux_select = reset & alu_reg_mux_s;
   assign illegal_instr      = reset & illegal_s;
   assign regfile_mux_select = reset ? regfile_mux_s : 2'b00;
   assign opsel1_select      = reset ? opsel1_s      : 2'b00;
   assign opsel2_select      = reset ? opsel2_s      : 2'b00;
   assign alu_sel            = reset ? alu_sel_s     : 4'd0;
   assign imm_src            = reset ? imm_src_s     : 4'd0;
   assign instr_mode         = reset ? instr_mode_s  : 2'b00;

endmodule
